mem_stage: RTL and testbench

Memory stage of the Chronos pipeline. It sits directly downstream of the EX stage (ALU, branch generator) and upstream of write-back.
- Holds the EX/MEM pipeline register.
- Runs load/store transactions on a req/ready/rvalid data-memory port, with byte/half/word alignment and sign extension.
- Selects the write-back value and drives a registered MEM/WB output.
- Stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory stage of the Chronos pipeline. Holds the EX/MEM pipeline
//            register, runs load/store transactions on a req/ready/rvalid
//            data-memory port (byte/half/word lanes, sign/zero extension),
//            selects the write-back value and drives a registered MEM/WB
//            output. Stalls upstream while a memory access is outstanding.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   ex_*                instruction presented by EX (valid, ALU result /
//                       effective address, store data, PC+4, rd, control)
//   mem_stall           freeze PC, IF/ID, ID/EX and EX (combinational)
//   dmem_req/addr/write/wdata/wmask
//                       request side of the data-memory port
//   dmem_ready          request accepted this cycle
//   dmem_rvalid/rdata   load response
//   wb_valid/rd/reg_write_en/data
//                       registered MEM/WB output (1-cycle valid pulse)
//   mem_exc/mem_exc_addr
//                       misaligned/illegal access pulse and faulting address
// ============================================================================
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] ex_pc4,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write_en,
  input  logic            ex_mem_req,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_mem_type,
  input  logic [2:0]      ex_wb_sel,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_write,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wmask,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write_en,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_exc,
  output logic [XLEN-1:0] mem_exc_addr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // --------------------------------------------------------------------------
  // EX/MEM holding register
  // --------------------------------------------------------------------------
  logic            h_valid;
  logic [XLEN-1:0] h_alu;
  logic [XLEN-1:0] h_sdata;
  logic [XLEN-1:0] h_pc4;
  logic [4:0]      h_rd;
  logic            h_we;
  logic            h_mem;
  logic            h_write;
  logic [2:0]      h_type;
  logic [2:0]      h_wbsel;

  logic            ex_bad;
  logic            h_bad;
  logic            h_is_mem;
  logic            capture;
  logic            complete;

  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_sel_data;

  // Returns 1 when a memory access cannot be issued: an undefined funct3 for
  // its direction, or an address not naturally aligned to the access size.
  // Bit [1:0] of funct3 encodes the size for both signed and unsigned forms.
  function automatic logic access_bad(input logic       write,
                                      input logic [2:0] ftype,
                                      input logic [1:0] a);
    logic illegal;
    logic misaligned;
    if (write) begin
      illegal = (ftype != 3'b000) && (ftype != 3'b001) && (ftype != 3'b010);
    end else begin
      illegal = (ftype == 3'b011) || (ftype == 3'b110) || (ftype == 3'b111);
    end
    misaligned = ((ftype[1:0] == 2'b01) && a[0]) ||
                 ((ftype[1:0] == 2'b10) && (a != 2'b00));
    return illegal || misaligned;
  endfunction

  assign ex_bad   = ex_mem_req && access_bad(ex_mem_write, ex_mem_type, ex_alu_out[1:0]);
  assign h_bad    = h_mem && access_bad(h_write, h_type, h_alu[1:0]);
  // A faulting access never touches the memory port, so it behaves like an
  // ALU instruction for sequencing purposes.
  assign h_is_mem = h_mem && !h_bad;

  // --------------------------------------------------------------------------
  // Completion detection. Kept separate from next-state logic because
  // capture depends on mem_stall, which in turn depends on complete.
  // --------------------------------------------------------------------------
  always_comb begin
    complete = 1'b0;
    case (state)
      ST_IDLE: complete = h_valid && !h_is_mem;
      ST_REQ:  complete = dmem_ready && h_write;
      ST_WAIT: complete = dmem_rvalid;
      default: complete = 1'b0;
    endcase
  end

  // Low in the completing cycle so the next instruction can be captured
  // on the same edge that retires the current one.
  assign mem_stall = h_valid && h_is_mem && !complete;
  assign capture   = ex_valid && !mem_stall;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_REQ: begin
        if (dmem_ready) begin
          state_nxt = h_write ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A newly captured instruction decides the next state on its own; capture
    // is only possible when the current entry is retiring or absent.
    if (capture) begin
      state_nxt = (ex_mem_req && !ex_bad) ? ST_REQ : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_valid <= 1'b0;
      h_alu   <= '0;
      h_sdata <= '0;
      h_pc4   <= '0;
      h_rd    <= '0;
      h_we    <= 1'b0;
      h_mem   <= 1'b0;
      h_write <= 1'b0;
      h_type  <= '0;
      h_wbsel <= '0;
    end else if (capture) begin
      h_valid <= 1'b1;
      h_alu   <= ex_alu_out;
      h_sdata <= ex_store_data;
      h_pc4   <= ex_pc4;
      h_rd    <= ex_rd;
      h_we    <= ex_reg_write_en;
      h_mem   <= ex_mem_req;
      h_write <= ex_mem_write;
      h_type  <= ex_mem_type;
      h_wbsel <= ex_wb_sel;
    end else if (complete) begin
      h_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Data-memory request side. Everything is driven from the holding register,
  // so address/data/mask are stable for as long as dmem_req is high. The
  // request is a pure state decode so reset removes it immediately.
  // --------------------------------------------------------------------------
  assign dmem_req   = (state == ST_REQ);
  assign dmem_addr  = {h_alu[XLEN-1:2], 2'b00};
  assign dmem_write = h_write;

  always_comb begin
    dmem_wdata = h_sdata;
    dmem_wmask = 4'b1111;
    case (h_type[1:0])
      2'b00: begin
        dmem_wdata = {4{h_sdata[7:0]}};
        dmem_wmask = 4'b0001 << h_alu[1:0];
      end
      2'b01: begin
        dmem_wdata = {2{h_sdata[15:0]}};
        dmem_wmask = h_alu[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dmem_wdata = h_sdata;
        dmem_wmask = 4'b1111;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Load formatting: pick the addressed lane, then sign/zero extend.
  // --------------------------------------------------------------------------
  always_comb begin
    lane_byte = dmem_rdata[7:0];
    case (h_alu[1:0])
      2'd0: lane_byte = dmem_rdata[7:0];
      2'd1: lane_byte = dmem_rdata[15:8];
      2'd2: lane_byte = dmem_rdata[23:16];
      2'd3: lane_byte = dmem_rdata[31:24];
      default: lane_byte = dmem_rdata[7:0];
    endcase
  end

  assign lane_half = h_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_data = dmem_rdata;
    case (h_type)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'b0, lane_byte};
      3'b101:  load_data = {16'b0, lane_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    wb_sel_data = h_alu;
    case (h_wbsel)
      3'd1:    wb_sel_data = load_data;
      3'd2:    wb_sel_data = h_pc4;
      default: wb_sel_data = h_alu;
    endcase
  end

  // --------------------------------------------------------------------------
  // MEM/WB register and exception reporting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid        <= 1'b0;
      wb_rd           <= '0;
      wb_reg_write_en <= 1'b0;
      wb_data         <= '0;
      mem_exc         <= 1'b0;
      mem_exc_addr    <= '0;
    end else begin
      wb_valid <= complete;
      mem_exc  <= complete && h_bad;
      if (complete) begin
        wb_rd   <= h_rd;
        wb_data <= wb_sel_data;
        // Stores and faulting accesses never write the register file, and
        // x0 is never written.
        wb_reg_write_en <= h_we && (h_rd != 5'd0) && !(h_mem && h_write) && !h_bad;
      end
      if (complete && h_bad) begin
        mem_exc_addr <= h_alu;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. A behavioural model predicts
//            each instruction's write-back record and memory-port image; a
//            compare process checks every MEM/WB output cycle against the
//            model, and directed vectors pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc4;
  logic [4:0]  ex_rd;
  logic        ex_reg_write_en;
  logic        ex_mem_req;
  logic        ex_mem_write;
  logic [2:0]  ex_mem_type;
  logic [2:0]  ex_wb_sel;
  logic        mem_stall;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_write;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write_en;
  logic [31:0] wb_data;
  logic        mem_exc;
  logic [31:0] mem_exc_addr;

  mem_stage #(.XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_alu_out      (ex_alu_out),
    .ex_store_data   (ex_store_data),
    .ex_pc4          (ex_pc4),
    .ex_rd           (ex_rd),
    .ex_reg_write_en (ex_reg_write_en),
    .ex_mem_req      (ex_mem_req),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_type     (ex_mem_type),
    .ex_wb_sel       (ex_wb_sel),
    .mem_stall       (mem_stall),
    .dmem_req        (dmem_req),
    .dmem_addr       (dmem_addr),
    .dmem_write      (dmem_write),
    .dmem_wdata      (dmem_wdata),
    .dmem_wmask      (dmem_wmask),
    .dmem_ready      (dmem_ready),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_reg_write_en (wb_reg_write_en),
    .wb_data         (wb_data),
    .mem_exc         (mem_exc),
    .mem_exc_addr    (mem_exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        known;
    logic        exc;
    logic [31:0] addr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_exc_addr = 32'h0;
  int          stall_cnt;
  logic [3:0]  last_wmask;
  logic [31:0] last_wdata;
  logic        last_write;
  logic [31:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write-back record an instruction must produce, from the architectural
  // rules: legality by direction, natural alignment by size, lane extraction
  // by shifting, and x0/store/fault write suppression.
  function automatic exp_t model(input logic mreq, input logic wr, input logic [2:0] ty,
                                 input logic [31:0] alu, input logic [31:0] pc4,
                                 input logic [4:0] rd, input logic we, input logic [2:0] sel,
                                 input logic [31:0] rdata);
    exp_t        e;
    bit          legal;
    bit          bad;
    int          a;
    int          size;
    logic [31:0] raw;
    logic [31:0] v;
    a = int'(alu % 32'd4);
    if (wr) legal = (ty <= 3'd2);
    else    legal = (ty inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = (ty % 3'd4 == 3'd0) ? 1 : (ty % 3'd4 == 3'd1) ? 2 : 4;
    bad  = mreq && (!legal || ((a % size) != 0));
    raw  = rdata >> (8 * a);
    case (ty)
      3'd0: begin v = raw & 32'd255;   if (v > 32'd127)   v = v | 32'hFFFF_FF00; end
      3'd1: begin v = raw & 32'd65535; if (v > 32'd32767) v = v | 32'hFFFF_0000; end
      3'd4: v = raw & 32'd255;
      3'd5: v = raw & 32'd65535;
      default: v = rdata;
    endcase
    e.rd    = rd;
    e.exc   = bad;
    e.addr  = alu;
    e.we    = we && (rd != 5'd0) && !(mreq && wr) && !bad;
    e.known = 1'b1;
    if (sel == 3'd2)      e.data = pc4;
    else if (sel == 3'd1) begin
      e.data  = v;
      e.known = mreq && !wr && !bad;
    end else              e.data = alu;
    return e;
  endfunction

  task automatic store_fmt(input logic [2:0] ty, input logic [31:0] alu, input logic [31:0] sd,
                           output logic [31:0] wdata, output logic [3:0] wmask);
    int a;
    a = int'(alu % 32'd4);
    case (ty)
      3'd0: begin wmask = 4'(1 << a); wdata = {24'b0, sd[7:0]} * 32'h0101_0101; end
      3'd1: begin wmask = 4'(3 << a); wdata = {16'b0, sd[15:0]} * 32'h0001_0001; end
      default: begin wmask = 4'hF; wdata = sd; end
    endcase
  endtask

  // Every cycle out of reset: each wb_valid pulse must match the oldest
  // outstanding prediction, and the exception address must track the model.
  always @(negedge clk) begin
    if (rst) begin
      if (wb_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: wb_valid=1 rd=%0d with nothing outstanding (t=%0t)", wb_rd, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.exc) model_exc_addr = e.addr;
          chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
          chk1("wb_we", wb_reg_write_en, e.we);
          chk1("wb_exc", mem_exc, e.exc);
          if (e.known) chk("wb_data", wb_data, e.data);
        end
      end else begin
        chk1("exc_idle", mem_exc, 1'b0);
      end
      chk("exc_addr", mem_exc_addr, model_exc_addr);
    end
  end

  task automatic check_dmem(input string tag, input logic wr, input logic [31:0] ea,
                            input logic [31:0] ew, input logic [3:0] em);
    chk({tag, "_addr"}, dmem_addr, ea);
    chk1({tag, "_write"}, dmem_write, wr);
    if (wr) begin
      chk({tag, "_wdata"}, dmem_wdata, ew);
      chk({tag, "_wmask"}, {28'b0, dmem_wmask}, {28'b0, em});
    end
  endtask

  // Issue one instruction and drive the memory handshake it needs.
  // rdy_dly: cycles with dmem_ready low; rv_dly: cycles from accept to rvalid.
  // junk_rv: pulse rvalid while still in the request phase (must be ignored).
  // bb: present an ALU op in the load's completing cycle.
  task automatic do_op(input logic mreq, input logic wr, input logic [2:0] ty,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic we, input logic [2:0] sel,
                       input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                       input bit junk_rv, input bit bb);
    exp_t        e;
    logic [31:0] ew;
    logic [3:0]  em;
    logic [31:0] ea;
    e  = model(mreq, wr, ty, alu, pc4, rd, we, sel, rdata);
    store_fmt(ty, alu, sd, ew, em);
    ea = alu - (alu % 32'd4);
    q.push_back(e);
    @(posedge clk); #1;
    ex_valid = 1'b1;  ex_alu_out = alu;  ex_store_data = sd;  ex_pc4 = pc4;
    ex_rd = rd;  ex_reg_write_en = we;  ex_mem_req = mreq;  ex_mem_write = wr;
    ex_mem_type = ty;  ex_wb_sel = sel;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    stall_cnt = 0;
    if (!mreq || e.exc) begin
      @(negedge clk);
      chk1("nm_stall", mem_stall, 1'b0);
      chk1("nm_req", dmem_req, 1'b0);
      @(posedge clk); #1;
      chk1("nm_wbv", wb_valid, 1'b1);
      chk1("nm_exc", mem_exc, e.exc);
    end else begin
      for (int i = 0; i < rdy_dly; i++) begin
        dmem_rvalid = junk_rv;
        dmem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("pend_req", dmem_req, 1'b1);
        chk1("pend_stall", mem_stall, 1'b1);
        check_dmem("pend", wr, ea, ew, em);
        if (mem_stall) stall_cnt++;
        @(posedge clk); #1;
      end
      dmem_rvalid = 1'b0;
      dmem_ready  = 1'b1;
      @(negedge clk);
      chk1("acc_req", dmem_req, 1'b1);
      chk1("acc_stall", mem_stall, !wr);
      check_dmem("acc", wr, ea, ew, em);
      if (mem_stall) stall_cnt++;
      last_wmask = dmem_wmask;
      last_wdata = dmem_wdata;
      last_write = dmem_write;
      last_addr  = dmem_addr;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      if (!wr) begin
        for (int i = 0; i < rv_dly - 1; i++) begin
          @(negedge clk);
          chk1("wait_stall", mem_stall, 1'b1);
          chk1("wait_req", dmem_req, 1'b0);
          if (mem_stall) stall_cnt++;
          @(posedge clk); #1;
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        if (bb) begin
          ex_valid = 1'b1;  ex_alu_out = 32'h77;  ex_rd = 5'd7;  ex_reg_write_en = 1'b1;
          ex_mem_req = 1'b0;  ex_mem_write = 1'b0;  ex_wb_sel = 3'd0;
          q.push_back(model(1'b0, 1'b0, 3'd0, 32'h77, 32'h0, 5'd7, 1'b1, 3'd0, 32'h0));
        end
        @(negedge clk);
        chk1("done_stall", mem_stall, 1'b0);
        chk1("done_req", dmem_req, 1'b0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'hDEAD_BEEF;
        ex_valid    = 1'b0;
      end
      chk1("mem_wbv", wb_valid, 1'b1);
      if (bb) begin
        @(posedge clk); #1;
        chk1("bb_wbv", wb_valid, 1'b1);
        chk("bb_data", wb_data, 32'h77);
      end
    end
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    q.delete();
    model_exc_addr = 32'h0;
  endtask

  initial begin
    ex_valid = 0;  ex_alu_out = 0;  ex_store_data = 0;  ex_pc4 = 0;  ex_rd = 0;
    ex_reg_write_en = 0;  ex_mem_req = 0;  ex_mem_write = 0;  ex_mem_type = 0;
    ex_wb_sel = 0;  dmem_ready = 0;  dmem_rvalid = 0;  dmem_rdata = 32'hDEAD_BEEF;
    enter_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_wbv", wb_valid, 1'b0);
    chk1("rst_we", wb_reg_write_en, 1'b0);
    chk("rst_data", wb_data, 32'h0);
    chk1("rst_exc", mem_exc, 1'b0);
    chk("rst_exc_addr", mem_exc_addr, 32'h0);
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ALU, JAL, and an rd=0 write that must be suppressed
    do_op(0, 0, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1, 3'd0, 32'h0, 0, 0, 0, 0);
    chk("alu_lit", wb_data, 32'h0000_1234);
    chk("alu_rd", {27'b0, wb_rd}, 32'd5);
    do_op(0, 0, 3'd0, 32'h0, 32'h0, 32'h108, 5'd1, 1, 3'd2, 32'h0, 0, 0, 0, 0);
    chk("jal_lit", wb_data, 32'h108);
    do_op(0, 0, 3'd0, 32'h55, 32'h0, 32'h0, 5'd0, 1, 3'd0, 32'h0, 0, 0, 0, 0);
    chk1("x0_we", wb_reg_write_en, 1'b0);

    // Loads: lane extraction and extension
    do_op(1, 0, 3'd0, 32'h103, 32'h0, 32'h0, 5'd6, 1, 3'd1, 32'h80FF_0000, 0, 1, 0, 0);
    chk("lb_lit", wb_data, 32'hFFFF_FF80);
    chk("lb_addr", last_addr, 32'h100);
    do_op(1, 0, 3'd4, 32'h103, 32'h0, 32'h0, 5'd6, 1, 3'd1, 32'h80FF_0000, 0, 1, 0, 0);
    chk("lbu_lit", wb_data, 32'h0000_0080);
    do_op(1, 0, 3'd1, 32'h102, 32'h0, 32'h0, 5'd6, 1, 3'd1, 32'h80FF_0000, 0, 1, 0, 0);
    chk("lh_lit", wb_data, 32'hFFFF_80FF);
    chk("lh_addr", last_addr, 32'h100);
    do_op(1, 0, 3'd5, 32'h102, 32'h0, 32'h0, 5'd6, 1, 3'd1, 32'h80FF_0000, 0, 1, 0, 0);
    chk("lhu_lit", wb_data, 32'h0000_80FF);
    do_op(1, 0, 3'd2, 32'h200, 32'h0, 32'h0, 5'd8, 1, 3'd1, 32'h1234_5678, 1, 1, 0, 0);
    chk("lw_lit", wb_data, 32'h1234_5678);

    // Stores
    do_op(1, 1, 3'd1, 32'h102, 32'hABCD_1234, 32'h0, 5'd0, 0, 3'd0, 32'h0, 0, 0, 0, 0);
    chk("sh_wmask", {28'b0, last_wmask}, 32'hC);
    chk("sh_wdata", last_wdata, 32'h1234_1234);
    chk1("sh_write", last_write, 1'b1);
    chk1("sh_we", wb_reg_write_en, 1'b0);
    do_op(1, 1, 3'd0, 32'h101, 32'h0000_0055, 32'h0, 5'd0, 0, 3'd0, 32'h0, 2, 0, 0, 0);
    chk("sb_wmask", {28'b0, last_wmask}, 32'h2);
    chk("sb_wdata", last_wdata, 32'h5555_5555);
    do_op(1, 1, 3'd2, 32'h204, 32'hCAFE_F00D, 32'h0, 5'd9, 1, 3'd0, 32'h0, 0, 0, 0, 0);
    chk("sw_wmask", {28'b0, last_wmask}, 32'hF);

    // Slow memory: ready after 3 cycles, rvalid 2 cycles after ready, stray
    // rvalid during the request phase, and an ALU op issued back to back
    do_op(1, 0, 3'd2, 32'h104, 32'h0, 32'h0, 5'd10, 1, 3'd1, 32'h0BAD_F00D, 3, 2, 1, 1);
    chk("slow_stall_cycles", 32'(stall_cnt), 32'd5);

    // Faulting accesses
    do_op(1, 1, 3'd3, 32'h100, 32'h1, 32'h0, 5'd0, 0, 3'd0, 32'h0, 0, 0, 0, 0);
    do_op(1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 5'd11, 1, 3'd1, 32'h0, 0, 0, 0, 0);
    chk("lw_mis_addr", mem_exc_addr, 32'h101);
    chk1("lw_mis_we", wb_reg_write_en, 1'b0);
    do_op(0, 0, 3'd0, 32'h42, 32'h0, 32'h0, 5'd12, 1, 3'd0, 32'h0, 0, 0, 0, 0);
    chk("exc_addr_hold", mem_exc_addr, 32'h101);

    // Reset while a load waits for rvalid
    @(posedge clk); #1;
    ex_valid = 1;  ex_alu_out = 32'h300;  ex_rd = 5'd3;  ex_reg_write_en = 1;
    ex_mem_req = 1;  ex_mem_write = 0;  ex_mem_type = 3'd2;  ex_wb_sel = 3'd1;
    @(posedge clk); #1;
    ex_valid = 0;
    dmem_ready = 1;
    @(posedge clk); #1;
    dmem_ready = 0;
    #1;
    chk1("wait_stall_pre", mem_stall, 1'b1);
    enter_reset();
    #1;
    chk1("rstw_req", dmem_req, 1'b0);
    chk1("rstw_wbv", wb_valid, 1'b0);
    chk1("rstw_stall", mem_stall, 1'b0);
    chk("rstw_exc_addr", mem_exc_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    dmem_rvalid = 1;
    dmem_rdata  = 32'h1111_2222;
    @(posedge clk); #1;
    dmem_rvalid = 0;
    repeat (2) begin
      @(negedge clk);
      chk1("rstw_no_wb", wb_valid, 1'b0);
    end

    // Reset while a store request is pending
    @(posedge clk); #1;
    ex_valid = 1;  ex_alu_out = 32'h400;  ex_store_data = 32'h9;  ex_rd = 5'd0;
    ex_reg_write_en = 0;  ex_mem_req = 1;  ex_mem_write = 1;  ex_mem_type = 3'd2;
    ex_wb_sel = 3'd0;
    @(posedge clk); #1;
    ex_valid = 0;
    chk1("rstr_req_pre", dmem_req, 1'b1);
    enter_reset();
    #1;
    chk1("rstr_req", dmem_req, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    dmem_ready = 1;
    @(posedge clk); #1;
    dmem_ready = 0;
    repeat (2) begin
      @(negedge clk);
      chk1("rstr_no_wb", wb_valid, 1'b0);
    end

    // Nothing predicted may remain unretired
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
